// File: rtl/gcd_req_queue_if.sv
// Val/rdy message channel between queue and its neighbours.
// master drives msg/val and samples rdy; slave is the reverse.
interface gcd_req_queue_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] msg;
  logic             val;
  logic             rdy;

  modport master (
    output msg,
    output val,
    input  rdy
  );

  modport slave (
    input  msg,
    input  val,
    output rdy
  );
endinterface

// File: rtl/gcd_req_queue.sv
// In-order elastic request queue in front of GcdUnit.
// Ports: clk, reset (sync, high), enq (slave ch), deq (master ch), count.
module gcd_req_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic            clk,
  input  logic            reset,
  gcd_req_queue_if.slave  enq,
  gcd_req_queue_if.master deq,
  output logic [CW-1:0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             full;
  logic             empty;
  logic             enq_fire;
  logic             deq_fire;

  // Ready/valid come from registered count only: no in->out path.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign enq.rdy  = !full;
  assign deq.val  = !empty;
  assign deq.msg  = mem[rp];
  assign enq_fire = enq.val && !full;
  assign deq_fire = deq.rdy && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (enq_fire)
        wp <= wp + AW'(1);
      if (deq_fire)
        rp <= rp + AW'(1);
      count <= count
             + CW'(enq_fire)
             - CW'(deq_fire);
    end
  end

  // Storage is not cleared on reset; pointers alone define contents.
  always_ff @(posedge clk) begin
    if (enq_fire && !reset)
      mem[wp] <= enq.msg;
  end
endmodule
